// File: rtl/snake_control.sv
// snake_control: control FSM for the snake datapath. Sequences body init, 2x2
// segment drawing, move period wait, head/body shift and tail erase.
module snake_control #(
  parameter int LENGTH      = 8,
  parameter int TICK_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  input  logic       i_key_up,
  input  logic       i_key_down,
  input  logic       i_key_left,
  input  logic       i_key_right,
  input  logic       i_dead,
  output logic       o_ld_head,
  output logic       o_ld_q_def,
  output logic       o_inc_address,
  output logic       o_rst_address,
  output logic       o_draw_q,
  output logic       o_update_head,
  output logic       o_ld_head_into_prev,
  output logic       o_ld_q_into_curr,
  output logic       o_ld_prev_into_q,
  output logic       o_ld_curr_into_prev,
  output logic       o_draw_curr,
  output logic [1:0] o_cnt_status,
  output logic [2:0] o_dir,
  output logic       o_erase
);
  localparam int                SEG_W     = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(LENGTH - 1);
  localparam logic [SEG_W-1:0]  SEG_ZERO  = SEG_W'(1'b0);
  localparam logic [SEG_W-1:0]  SEG_ONE   = SEG_W'(1'b1);
  localparam logic [23:0]       TICK_LAST = 24'(TICK_CYCLES - 1);
  localparam logic [2:0] DIR_UP = 3'b100, DIR_DOWN = 3'b110, DIR_LEFT = 3'b000, DIR_RIGHT = 3'b001;

  // Strobe vector bit order: ld_head, ld_q_def, inc, rst, draw_q, update_head,
  // head->prev, q->curr, prev->q, curr->prev, draw_curr, erase.
  localparam logic [11:0] ST_LDH = 12'h800, ST_LQD = 12'h400, ST_INC = 12'h200, ST_RST = 12'h100;
  localparam logic [11:0] ST_DRQ = 12'h080, ST_UPD = 12'h040, ST_HIP = 12'h020, ST_QIC = 12'h010;
  localparam logic [11:0] ST_PIQ = 12'h008, ST_CIP = 12'h004, ST_DC  = 12'h002, ST_ER  = 12'h001;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_INIT_END, S_DRAW_WAIT, S_DRAW_PIX, S_TICK, S_MOVE_HEAD,
    S_MOVE_PREV, S_SH_WAIT, S_SH_XCHG, S_SH_NEXT, S_ERASE, S_DEAD
  } state_t;

  state_t           r_state, w_state;
  logic [SEG_W-1:0] r_seg, w_seg;
  logic [1:0]       r_cnt, w_cnt;
  logic [23:0]      r_tick, w_tick;
  logic [2:0]       r_cur_dir, w_cur_dir, r_pend_dir, w_pend_dir, w_req;
  logic             w_req_vld;
  logic [11:0]      r_strobes;

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = DIR_DOWN;
    endcase
  endfunction

  function automatic logic [11:0] decode(input state_t s, input logic [SEG_W-1:0] seg,
                                         input logic [1:0] cnt);
    logic [11:0] addr_step;
    addr_step = (seg == SEG_LAST) ? ST_RST : ST_INC;
    case (s)
      S_INIT:      decode = ST_LQD | ST_INC;
      S_INIT_END:  decode = ST_LDH | ST_RST;
      S_DRAW_PIX:  decode = ST_DRQ | ((cnt == 2'b11) ? addr_step : 12'h000);
      S_MOVE_HEAD: decode = ST_UPD;
      S_MOVE_PREV: decode = ST_HIP;
      S_SH_XCHG:   decode = ST_QIC | ST_PIQ;
      S_SH_NEXT:   decode = ST_CIP | addr_step;
      S_ERASE:     decode = ST_DC | ST_ER;
      default:     decode = 12'h000;
    endcase
  endfunction

  // Highest-priority key request this cycle.
  always_comb begin
    w_req     = DIR_UP;
    w_req_vld = 1'b1;
    if (i_key_up) begin
      w_req = DIR_UP;
    end else if (i_key_down) begin
      w_req = DIR_DOWN;
    end else if (i_key_left) begin
      w_req = DIR_LEFT;
    end else if (i_key_right) begin
      w_req = DIR_RIGHT;
    end else begin
      w_req_vld = 1'b0;
    end
  end

  // Next-state, segment, pixel counter, tick counter and direction logic.
  always_comb begin
    w_state    = r_state;
    w_seg      = r_seg;
    w_cnt      = 2'b00;
    w_tick     = r_tick;
    w_cur_dir  = r_cur_dir;
    w_pend_dir = r_pend_dir;
    // Reversal is judged against the committed direction, not the pending one.
    if (r_state != S_IDLE && r_state != S_DEAD && w_req_vld && w_req != opposite(r_cur_dir)) begin
      w_pend_dir = w_req;
    end else begin
      w_pend_dir = r_pend_dir;
    end
    case (r_state)
      S_IDLE: w_state = i_go ? S_INIT : S_IDLE;
      S_INIT: begin
        if (r_seg == SEG_LAST) begin
          w_state = S_INIT_END;
          w_seg   = SEG_ZERO;
        end else begin
          w_seg = r_seg + SEG_ONE;
        end
      end
      S_INIT_END:  w_state = S_DRAW_WAIT;
      S_DRAW_WAIT: w_state = S_DRAW_PIX;
      S_DRAW_PIX, S_ERASE: begin
        w_cnt = r_cnt + 2'b01;
        if (r_cnt != 2'b11) begin
          w_state = r_state;
        end else if (r_state == S_ERASE) begin
          w_state = S_DRAW_WAIT;
        end else if (r_seg == SEG_LAST) begin
          w_state = S_TICK;
          w_seg   = SEG_ZERO;
          w_tick  = 24'd0;
        end else begin
          w_state = S_DRAW_WAIT;
          w_seg   = r_seg + SEG_ONE;
        end
      end
      S_TICK: begin
        if (r_tick == TICK_LAST) begin
          w_cur_dir = w_pend_dir;
          w_state   = i_dead ? S_DEAD : S_MOVE_HEAD;
        end else begin
          w_tick = r_tick + 24'd1;
        end
      end
      S_MOVE_HEAD: w_state = S_MOVE_PREV;
      S_MOVE_PREV: w_state = S_SH_WAIT;
      S_SH_WAIT:   w_state = S_SH_XCHG;
      S_SH_XCHG:   w_state = S_SH_NEXT;
      S_SH_NEXT: begin
        if (r_seg == SEG_LAST) begin
          w_state = S_ERASE;
          w_seg   = SEG_ZERO;
        end else begin
          w_state = S_SH_WAIT;
          w_seg   = r_seg + SEG_ONE;
        end
      end
      S_DEAD: begin
        if (i_go) begin
          w_state    = S_INIT;
          w_cur_dir  = DIR_UP;
          w_pend_dir = DIR_UP;
        end else begin
          w_state = S_DEAD;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State registers; strobes are registered from the next-state decode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_seg      <= SEG_ZERO;
      r_cnt      <= 2'b00;
      r_tick     <= 24'd0;
      r_cur_dir  <= DIR_UP;
      r_pend_dir <= DIR_UP;
      r_strobes  <= 12'h000;
    end else begin
      r_state    <= w_state;
      r_seg      <= w_seg;
      r_cnt      <= w_cnt;
      r_tick     <= w_tick;
      r_cur_dir  <= w_cur_dir;
      r_pend_dir <= w_pend_dir;
      r_strobes  <= decode(w_state, w_seg, w_cnt);
    end
  end

  assign {o_ld_head, o_ld_q_def, o_inc_address, o_rst_address, o_draw_q, o_update_head,
          o_ld_head_into_prev, o_ld_q_into_curr, o_ld_prev_into_q, o_ld_curr_into_prev,
          o_draw_curr, o_erase} = r_strobes;
  assign o_cnt_status = r_cnt;
  assign o_dir        = r_cur_dir;

endmodule
